pc_next_unit: RTL

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Program-counter sequencer. It steps the PC by one each cycle and can be
//   redirected by a jump or a taken branch. After a redirect it raises flush
//   for FLUSH_CYCLES non-stalled cycles to squash the instructions fetched on
//   the wrong path. Redirect requests that arrive while flush is high come
//   from squashed instructions, so they are ignored.
//
// Parameters
//   WIDTH        PC / target width in bits
//   PC_RESET     PC value forced by reset
//   FLUSH_CYCLES flush length after a redirect (1..7)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC and flush counter (overridden by a redirect in RUN)
//   jump           unconditional redirect (has priority over branch_taken)
//   jump_target    jump destination
//   branch_taken   conditional redirect, branch resolved taken
//   branch_target  branch destination
//   pc             registered current PC
//   pc_plus1       combinational pc+1, wraps modulo 2^WIDTH
//   flush          registered squash flag, high exactly while in FLUSH
//   redirect_count saturating count of accepted redirects
module pc_next_unit #(
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   PC_RESET     = '0,
  parameter int                 FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             flush,
  output logic [7:0]       redirect_count
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t           state;
  logic [2:0]       flush_cnt;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  // During reset pc is PC_RESET, so this is PC_RESET+1 as well.
  assign pc_plus1    = pc + WIDTH'(1);
  assign redirect    = jump | branch_taken;
  assign redirect_pc = jump ? jump_target : branch_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      pc             <= PC_RESET;
      flush          <= 1'b0;
      flush_cnt      <= 3'd0;
      redirect_count <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          // A redirect wins over stall: the target is taken on this edge.
          if (redirect) begin
            pc        <= redirect_pc;
            flush_cnt <= FLUSH_LOAD;
            state     <= FLUSH;
            flush     <= 1'b1;
            if (redirect_count != 8'hFF)
              redirect_count <= redirect_count + 8'd1;
          end else if (!stall) begin
            pc <= pc_plus1;
          end
        end
        FLUSH: begin
          // jump/branch_taken are not looked at here; everything holds on stall.
          if (!stall) begin
            pc        <= pc_plus1;
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) begin
              state <= RUN;
              flush <= 1'b0;
            end
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule
